// File: rtl/scan_ctrl_pkg.sv
// Shared types and defaults for the scan-test sequencer and its MISR.
package scan_ctrl_pkg;

  localparam int CNT_W = 16;

  // x^16 + x^12 + x^3 + x + 1
  localparam logic [15:0] DEF_MISR_POLY = 16'h100B;
  localparam logic [15:0] DEF_MISR_SEED = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CAPTURE,
    ST_SHIFT,
    ST_UNLOAD,
    ST_DONE
  } state_t;

endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register: Galois-style shift with per-bit
// feedback taps, XORing N parallel scan-out bits into the low bits.
module misr_reg #(
  parameter int           W    = 16,
  parameter int           N    = 4,
  parameter logic [W-1:0] POLY = 16'h100B,
  parameter logic [W-1:0] SEED = 16'h0000
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         init,
  input  logic         en,
  input  logic [N-1:0] din,
  output logic [W-1:0] sig
);

  logic [W-1:0] din_ext;
  logic [W-1:0] fb_mask;
  logic [W-1:0] sig_next;

  assign din_ext  = W'(din);
  assign fb_mask  = sig[W-1] ? POLY : '0;
  // Bit 0 shifts in a zero, so only the feedback tap and din[0] reach it.
  assign sig_next = {sig[W-2:0], 1'b0} ^ fb_mask ^ din_ext;

  // NOTE: sequential state is assigned with <= so every register samples
  // the pre-edge value of its neighbours, which is what a shift chain needs.
  always_ff @(posedge CLK) begin
    if (reset || init) begin
      sig <= SEED;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/scan_misr_ctrl.sv
// Scan-test sequencer: drives scan_en through load/capture/unload for a
// number of patterns, compacts scan-out into a MISR and checks the result.
module scan_misr_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int                    NUM_CHAINS = 4,
  parameter int                    CHAIN_LEN  = 8,
  parameter int                    MISR_WIDTH = 16,
  parameter logic [MISR_WIDTH-1:0] MISR_POLY  = DEF_MISR_POLY,
  parameter logic [MISR_WIDTH-1:0] MISR_SEED  = DEF_MISR_SEED
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_patterns,
  input  logic [MISR_WIDTH-1:0] expected_sig,
  input  logic [NUM_CHAINS-1:0] ScanChainOut,
  output logic                  scan_en,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [MISR_WIDTH-1:0] signature,
  output logic [CNT_W-1:0]      pattern_cnt
);

  localparam int             SC_W       = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [SC_W-1:0] SHIFT_LAST = SC_W'(CHAIN_LEN - 1);

  state_t                  state;
  state_t                  state_next;
  logic [SC_W-1:0]         shift_cnt;
  logic [CNT_W-1:0]        num_pat_q;
  logic [MISR_WIDTH-1:0]   exp_sig_q;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    start_ok;
  logic                    shifting;
  logic                    compact;
  logic                    shift_last;

  assign start_ok   = start && (state == ST_IDLE || state == ST_DONE);
  assign shift_last = (shift_cnt == SHIFT_LAST);
  // pattern_cnt never exceeds num_pat_q (max 16'hFFFF), so this cannot wrap.
  assign cnt_inc    = pattern_cnt + 1'b1;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    shifting   = 1'b0;
    compact    = 1'b0;
    busy       = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_next = (num_patterns == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        shifting = 1'b1;
        busy     = 1'b1;
        if (shift_last) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        busy       = 1'b1;
        state_next = (cnt_inc < num_pat_q) ? ST_SHIFT : ST_UNLOAD;
      end
      ST_SHIFT: begin
        shifting = 1'b1;
        compact  = 1'b1;
        busy     = 1'b1;
        if (shift_last) state_next = ST_CAPTURE;
      end
      ST_UNLOAD: begin
        shifting = 1'b1;
        compact  = 1'b1;
        busy     = 1'b1;
        if (shift_last) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign scan_en = shifting;
  assign done    = (state == ST_DONE);

  always_ff @(posedge CLK) begin
    if (reset) begin
      shift_cnt   <= '0;
      pattern_cnt <= '0;
      num_pat_q   <= '0;
      exp_sig_q   <= '0;
    end else begin
      if (shifting) begin
        shift_cnt <= shift_last ? '0 : shift_cnt + 1'b1;
      end else begin
        shift_cnt <= '0;
      end

      if (start_ok) begin
        pattern_cnt <= '0;
        num_pat_q   <= num_patterns;
        exp_sig_q   <= expected_sig;
      end else if (state == ST_CAPTURE) begin
        pattern_cnt <= cnt_inc;
      end
    end
  end

  misr_reg #(
    .W    (MISR_WIDTH),
    .N    (NUM_CHAINS),
    .POLY (MISR_POLY),
    .SEED (MISR_SEED)
  ) u_misr (
    .CLK   (CLK),
    .reset (reset),
    .init  (start_ok),
    .en    (compact),
    .din   (ScanChainOut),
    .sig   (signature)
  );

  // Both operands are registers frozen throughout DONE, so the verdict is
  // settled from the first DONE cycle and stable until the next start.
  assign pass = done && (signature == exp_sig_q);

endmodule

// File: tb/tb_scan_misr_ctrl.sv
// Directed bench for scan_misr_ctrl with a reference MISR model and an
// expected-result queue popped when each session reports done.
module tb_scan_misr_ctrl;
  import scan_ctrl_pkg::*;

  localparam int          L    = 8;
  localparam int          NC   = 4;
  localparam int          W    = 16;
  localparam logic [15:0] POLY = 16'h100B;
  localparam logic [15:0] SEED = 16'h0000;

  logic          CLK;
  logic          reset;
  logic          start;
  logic [15:0]   num_patterns;
  logic [W-1:0]  expected_sig;
  logic [NC-1:0] ScanChainOut;
  logic          scan_en;
  logic          busy;
  logic          done;
  logic          pass;
  logic [W-1:0]  signature;
  logic [15:0]   pattern_cnt;

  typedef struct {
    logic [15:0] sig;
    logic        pass;
    logic [15:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] data_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  scan_misr_ctrl #(
    .NUM_CHAINS (NC),
    .CHAIN_LEN  (L),
    .MISR_WIDTH (W),
    .MISR_POLY  (POLY),
    .MISR_SEED  (SEED)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .start        (start),
    .num_patterns (num_patterns),
    .expected_sig (expected_sig),
    .ScanChainOut (ScanChainOut),
    .scan_en      (scan_en),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .signature    (signature),
    .pattern_cnt  (pattern_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference MISR step: shift up, apply taps when the top bit falls out,
  // and fold the chain bits into the low positions.
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [3:0] d);
    logic [15:0] r;
    r = {s[14:0], 1'b0};
    if (s[15]) r = r ^ POLY;
    r[3:0] = r[3:0] ^ d;
    return r;
  endfunction

  // Busy cycle t: LOAD for t<L, then per pattern one CAPTURE and L shifts.
  function automatic bit is_compact(input int t);
    return (t >= L) && (((t - L) % (L + 1)) != 0);
  endfunction

  // mode: 0 zeros, 1 single bit on last unload cycle, 2 random, 3 reuse data.
  task automatic run_session(input string tag, input int np, input int mode,
                             input bit flip, input int glitch_t);
    int          tt;
    int          t;
    int          en_err;
    logic [15:0] m;
    exp_t        e;
    exp_t        got;
    tt = np * (L + 1) + L;
    if (mode != 3) begin
      data_q.delete();
      for (int i = 0; i < tt; i++) begin
        if (mode == 0)      data_q.push_back(4'h0);
        else if (mode == 1) data_q.push_back((i == tt - 1) ? 4'h1 : 4'h0);
        else                data_q.push_back(4'($urandom));
      end
    end
    m = SEED;
    for (int i = 0; i < tt; i++) begin
      if (is_compact(i)) m = misr_step(m, data_q[i]);
    end
    e.sig  = m;
    e.pass = !flip;
    e.cnt  = 16'(np);
    sb.push_back(e);

    @(negedge CLK);
    start        = 1'b1;
    num_patterns = 16'(np);
    expected_sig = flip ? (m ^ 16'h0001) : m;
    @(negedge CLK);
    start  = 1'b0;
    t      = 0;
    en_err = 0;
    while (busy && t < tt + 4) begin
      if (t == 0) check({tag, "_done_clear"}, 32'(done), 32'd0);
      if (t < tt && scan_en !== 1'(t < L || is_compact(t))) en_err++;
      ScanChainOut = (t < tt) ? data_q[t] : 4'h0;
      if (t == glitch_t) begin
        start        = 1'b1;
        num_patterns = 16'd0;
        expected_sig = ~expected_sig;
      end else begin
        start = 1'b0;
      end
      @(negedge CLK);
      t++;
    end
    start        = 1'b0;
    ScanChainOut = '0;
    check({tag, "_busy_cycles"}, 32'(t), 32'(tt));
    check({tag, "_scan_en_seq"}, 32'(en_err), 32'd0);
    got = sb.pop_front();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_pass"}, 32'(pass), 32'(got.pass));
    check({tag, "_signature"}, 32'(signature), 32'(got.sig));
    check({tag, "_pattern_cnt"}, 32'(pattern_cnt), 32'(got.cnt));
  endtask

  initial begin
    exp_t e;
    int   en_err;
    reset        = 1'b1;
    start        = 1'b0;
    num_patterns = '0;
    expected_sig = '0;
    ScanChainOut = '0;
    repeat (3) @(negedge CLK);

    check("rst_scan_en", 32'(scan_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_signature", 32'(signature), 32'(SEED));
    check("rst_pattern_cnt", 32'(pattern_cnt), 32'd0);

    // Start coincident with reset: reset wins, nothing launches.
    start        = 1'b1;
    num_patterns = 16'd2;
    @(negedge CLK);
    reset = 1'b0;
    start = 1'b0;
    @(negedge CLK);
    check("rst_start_busy", 32'(busy), 32'd0);
    check("rst_start_scan_en", 32'(scan_en), 32'd0);

    run_session("np2_zero", 2, 0, 1'b0, -1);
    // Launched while done=1 from the previous session.
    run_session("np1_lastbit", 1, 1, 1'b0, -1);

    // Zero patterns: straight to DONE, signature stays at the seed.
    e.sig  = SEED;
    e.pass = (SEED == 16'h1234);
    e.cnt  = 16'd0;
    sb.push_back(e);
    @(negedge CLK);
    start        = 1'b1;
    num_patterns = 16'd0;
    expected_sig = 16'h1234;
    @(negedge CLK);
    start = 1'b0;
    e = sb.pop_front();
    check("np0_done", 32'(done), 32'd1);
    check("np0_pass", 32'(pass), 32'(e.pass));
    check("np0_signature", 32'(signature), 32'(e.sig));
    check("np0_busy", 32'(busy), 32'd0);
    en_err = 0;
    repeat (3) begin
      if (scan_en !== 1'b0) en_err++;
      @(negedge CLK);
    end
    check("np0_scan_en_quiet", 32'(en_err), 32'd0);

    run_session("np5_rand", 5, 2, 1'b0, -1);
    run_session("np5_rand_flip", 5, 3, 1'b1, -1);
    // Start pulse at busy cycle 12 lands in the first SHIFT and must be ignored.
    run_session("np3_glitch", 3, 2, 1'b0, 12);

    // Reset in the middle of a SHIFT.
    data_q.delete();
    @(negedge CLK);
    start        = 1'b1;
    num_patterns = 16'd3;
    expected_sig = 16'h0000;
    @(negedge CLK);
    start = 1'b0;
    for (int t = 0; t < 13; t++) begin
      ScanChainOut = 4'hA;
      @(negedge CLK);
    end
    check("mid_pattern_cnt", 32'(pattern_cnt), 32'd1);
    check("mid_scan_en", 32'(scan_en), 32'd1);
    reset = 1'b1;
    @(negedge CLK);
    reset        = 1'b0;
    ScanChainOut = '0;
    check("mid_rst_scan_en", 32'(scan_en), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_signature", 32'(signature), 32'(SEED));
    check("mid_rst_pattern_cnt", 32'(pattern_cnt), 32'd0);
    @(negedge CLK);
    check("mid_rst_stays_idle", 32'(busy), 32'd0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_misr_ctrl.md
Name: scan_misr_ctrl

Overview:
Scan-test sequencer and response compactor that sits directly downstream of the EX_Core scan chains.
- Drives the core's SCANMODE (scan_en) through a load / capture / unload sequence.
- Compacts the 4 ScanChainOut bits per shift cycle into a multiple-input signature register (MISR).
- Compares the final signature against an expected value and reports pass/fail.
- One instance per wrapped core; the wrapper's TAP/WIR logic configures it through its control ports.

Parameters:
NUM_CHAINS, 4, number of scan chains compacted (must be ≤ MISR_WIDTH)
CHAIN_LEN, 8, shift cycles per load/unload (length of the longest chain)
MISR_WIDTH, 16, signature width
MISR_POLY, 16'h100B, feedback tap mask (x^16+x^12+x^3+x+1)
MISR_SEED, 16'h0000, signature value after start

Ports:
CLK  in  1  single clock, rising edge
reset  in  1  synchronous, active-high; clears all state
start  in  1  one-cycle pulse; begins a session (ignored unless IDLE or DONE)
num_patterns  in  16  pattern count, sampled on accepted start
expected_sig  in  MISR_WIDTH  golden signature, sampled on accepted start
ScanChainOut  in  NUM_CHAINS  scan-out bits from the core
scan_en  out  1  to core SCANMODE; 1 = shift, 0 = capture/functional
busy  out  1  high from the cycle after start through the last unload cycle
done  out  1  high in DONE; held until next accepted start or reset
pass  out  1  valid when done: signature == expected_sig
signature  out  MISR_WIDTH  current MISR contents
pattern_cnt  out  16  patterns captured so far

Behaviour:
- Reset values: state=IDLE; scan_en, busy, done, pass, pattern_cnt = 0; signature = MISR_SEED.
- FSM states: IDLE, LOAD, CAPTURE, SHIFT, UNLOAD, DONE.
- Shift counter: 0..CHAIN_LEN-1.
- Accepted start (state IDLE or DONE):
  - Latch num_patterns and expected_sig; signature <= MISR_SEED; pattern_cnt <= 0; done <= 0.
  - If num_patterns == 0: next state DONE; pass = (MISR_SEED == expected_sig).
  - Otherwise: next state LOAD.
- LOAD: scan_en=1 for CHAIN_LEN cycles; no compaction (scan-out is don't-care); then CAPTURE.
- CAPTURE: scan_en=0 for exactly 1 cycle; pattern_cnt += 1.
  - If the new pattern_cnt < num_patterns: next state SHIFT.
  - Otherwise: next state UNLOAD.
- SHIFT: scan_en=1 for CHAIN_LEN cycles; compaction enabled every cycle (unloads pattern k-1 while loading pattern k); then CAPTURE.
- UNLOAD: scan_en=1 for CHAIN_LEN cycles with compaction; then DONE.
- DONE: pass registered on entry; scan_en=0.
- busy = state in {LOAD, CAPTURE, SHIFT, UNLOAD}.
- Total busy cycles = num_patterns*(CHAIN_LEN+1) + CHAIN_LEN.
- MISR update on a compaction cycle, with fb = sig[W-1]:
  - sig'[i] = sig[i-1] ^ (fb & POLY[i]) ^ (i < NUM_CHAINS ? ScanChainOut[i] : 0)
  - sig[-1] is taken as 0.
- ScanChainOut is sampled on the same CLK edge that advances the shift counter.
- Boundary conditions:
  - start while busy: ignored, no effect.
  - reset mid-session: returns to IDLE next edge, scan_en drops to 0.
  - pattern_cnt does not wrap: num_patterns max is 16'hFFFF.
  - start and reset in the same cycle: reset wins.

Decomposition:
- Package scan_ctrl_pkg: state enum; default MISR_POLY/MISR_SEED constants; counter width constant (16).
- Sub-module misr_reg (parameters W, N, POLY, SEED; ports CLK, reset, init, en, din[N-1:0], sig[W-1:0]): holds the signature register and update equation.
- Top level holds the FSM, counters and compare.

Test Plan:
- num_patterns=2, ScanChainOut=0: scan_en high 8, low 1, high 8, low 1, high 8; busy for 26 cycles; signature=16'h0000; pass=1 with expected_sig=0.
- num_patterns=1, ScanChainOut[0]=1 only on the last UNLOAD cycle: signature=16'h0001, pattern_cnt=1, done=1.
- num_patterns=0, expected_sig=16'h1234: done the cycle after start, pass=0, scan_en never asserted.
- Random ScanChainOut, num_patterns=5, expected_sig from the bench reference model: pass=1; same run with one flipped bit: pass=0.
- Second start pulse mid-SHIFT: ignored; reset asserted mid-SHIFT: next cycle IDLE, scan_en=0, signature=MISR_SEED.
- Start asserted while done=1: done clears, new session runs from LOAD.
